// File: rtl/mmap_perf_pkg.sv
// Shared register map and CTRL bit positions for the perf register block.
package mmap_perf_pkg;

    // Word offsets inside the 64-word window
    localparam logic [5:0] OFF_CTRL      = 6'h00;
    localparam logic [5:0] OFF_MASK      = 6'h01;
    localparam logic [5:0] OFF_CLR       = 6'h02;
    localparam logic [5:0] OFF_SNAP      = 6'h03;
    localparam logic [5:0] OFF_TIMER     = 6'h04;
    localparam logic [5:0] OFF_PRESC     = 6'h05;
    localparam logic [5:0] OFF_CMP       = 6'h06;
    localparam logic [5:0] OFF_STATUS    = 6'h07;
    localparam logic [5:0] OFF_KEYLVL    = 6'h08;
    localparam logic [5:0] OFF_CNT_BASE  = 6'h10;
    localparam logic [5:0] OFF_SNAP_BASE = 6'h20;

    // CTRL register bit indices
    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_TMR_EN = 1;
    localparam int CTRL_IRQ_EN = 2;

endpackage

// File: rtl/mmap_perf_regs_counter.sv
// One event counter channel: live count plus snapshot copy.
// Clear beats increment; snapshot always captures the value before this edge.
module perf_counter #(
    parameter int DATA_W   = 16,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic              en,
    input  logic              snap,
    output logic [DATA_W-1:0] cnt,
    output logic [DATA_W-1:0] snap_cnt
);

    // Live counter with clear priority and saturate-or-wrap at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && en) begin
            if ((cnt == '1) && (SATURATE != 0)) begin
                cnt <= cnt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Snapshot samples the pre-update live value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cnt <= '0;
        end else if (snap) begin
            snap_cnt <= cnt;
        end
    end

endmodule

// File: rtl/mmap_perf_regs.sv
// Memory-mapped perf block: event counters, prescaled timer, key edge capture, irq.
// Bus: a transfer is addr/wdata qualified by mm_we (write, applied at the next clk
// edge) or mm_re (read, rdata valid combinationally in the same cycle); there is no
// ready/stall, every strobe completes in its own cycle and a read beside a write
// sees the pre-write contents.
module mmap_perf_regs
    import mmap_perf_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC040,
    parameter int          DATA_W    = 16,
    parameter int          NUM_CNT   = 4,
    parameter int          NUM_KEYS  = 2,
    parameter int          SATURATE  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mm_we,
    input  logic                mm_re,
    input  logic [15:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    input  logic [NUM_CNT-1:0]  inc,
    input  logic [NUM_KEYS-1:0] key,
    output logic                irq
);

    logic                hit;
    logic [5:0]          off;
    logic [2:0]          ctrl_q;
    logic [NUM_CNT-1:0]  mask_q;
    logic [DATA_W-1:0]   timer_q, presc_q, cmp_q, pre_cnt;
    logic [NUM_KEYS:0]   status_q;
    logic [NUM_KEYS-1:0] key_s1, key_s2, key_hist, key_rise;
    logic [NUM_CNT-1:0]  clr_vec;
    logic                snap_wr, timer_wr, status_wr, tick, match;
    logic [NUM_KEYS:0]   w1c;
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   live  [NUM_CNT];
    logic [DATA_W-1:0]   snaps [NUM_CNT];

    assign hit       = (addr[15:6] == BASE_ADDR[15:6]);
    assign off       = addr[5:0];
    assign snap_wr   = mm_we && hit && (off == OFF_SNAP);
    assign timer_wr  = mm_we && hit && (off == OFF_TIMER);
    assign status_wr = mm_we && hit && (off == OFF_STATUS);
    assign clr_vec   = (mm_we && hit && (off == OFF_CLR)) ? wdata[NUM_CNT-1:0] : '0;
    assign w1c       = status_wr ? wdata[NUM_KEYS:0] : '0;
    assign tick      = ctrl_q[CTRL_TMR_EN] && (pre_cnt == presc_q);
    assign match     = tick && !timer_wr && (timer_q == cmp_q);
    assign key_rise  = key_s2 & ~key_hist;

    // Plain RW configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            mask_q  <= '0;
            presc_q <= '0;
            cmp_q   <= '0;
        end else if (mm_we && hit) begin
            case (off)
                OFF_CTRL:  ctrl_q  <= wdata[2:0];
                OFF_MASK:  mask_q  <= wdata[NUM_CNT-1:0];
                OFF_PRESC: presc_q <= wdata;
                OFF_CMP:   cmp_q   <= wdata;
                default:   ;
            endcase
        end
    end

    // Prescaler and auto-reload timer; a bus load discards a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            pre_cnt <= '0;
        end else if (timer_wr) begin
            timer_q <= wdata;
            pre_cnt <= '0;
        end else if (ctrl_q[CTRL_TMR_EN]) begin
            if (tick) begin
                pre_cnt <= '0;
                timer_q <= match ? '0 : timer_q + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Two-flop key synchroniser plus history flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_hist <= '0;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_hist <= key_s2;
        end
    end

    // Sticky status with W1C; a new event in the clearing cycle keeps the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            irq      <= 1'b0;
        end else begin
            status_q <= (status_q & ~w1c) | {key_rise, match};
            irq      <= ctrl_q[CTRL_IRQ_EN] && (|status_q);
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr_vec[g]),
            .inc      (inc[g]),
            .en       (ctrl_q[CTRL_CNT_EN] && mask_q[g]),
            .snap     (snap_wr),
            .cnt      (live[g]),
            .snap_cnt (snaps[g])
        );
    end

    // Read decode; unmapped offsets and absent channels return 0
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CTRL:   rd_mux = DATA_W'(ctrl_q);
            OFF_MASK:   rd_mux = DATA_W'(mask_q);
            OFF_TIMER:  rd_mux = timer_q;
            OFF_PRESC:  rd_mux = presc_q;
            OFF_CMP:    rd_mux = cmp_q;
            OFF_STATUS: rd_mux = DATA_W'(status_q);
            OFF_KEYLVL: rd_mux = DATA_W'(key_s2);
            default: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if (off == OFF_CNT_BASE + 6'(i))  rd_mux = live[i];
                    if (off == OFF_SNAP_BASE + 6'(i)) rd_mux = snaps[i];
                end
            end
        endcase
    end

    assign rdata = (mm_re && hit) ? rd_mux : '0;

endmodule

// File: tb/tb_mmap_perf_regs.sv
// Directed bench for mmap_perf_regs: two instances, saturating and wrapping.
module tb_mmap_perf_regs;

  localparam logic [15:0] B = 16'hC040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mm_we = 1'b0;
  logic        mm_re = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  inc = '0;
  logic [1:0]  key = '0;
  logic [15:0] rdata, rdata_w;
  logic        irq, irq_w;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  mmap_perf_regs #(.BASE_ADDR(B), .DATA_W(16), .NUM_CNT(4), .NUM_KEYS(2), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .mm_we(mm_we), .mm_re(mm_re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .inc(inc), .key(key), .irq(irq)
  );

  mmap_perf_regs #(.BASE_ADDR(B), .DATA_W(16), .NUM_CNT(4), .NUM_KEYS(2), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .mm_we(mm_we), .mm_re(mm_re), .addr(addr),
    .wdata(wdata), .rdata(rdata_w), .inc(inc), .key(key), .irq(irq_w)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: write captured at the posedge following the first negedge
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    mm_we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    mm_we = 1'b0;
  endtask

  // driver: combinational read in the low clock phase, no clock wait
  task automatic bus_read(input logic [15:0] a, input bit use_w, output logic [15:0] d);
    addr = a; mm_re = 1'b1;
    #1;
    d = use_w ? rdata_w : rdata;
    mm_re = 1'b0;
  endtask

  // scoreboard: expected value queued, popped against the observed read
  task automatic read_chk(input string tag, input logic [15:0] a, input bit use_w,
                          input logic [15:0] exp);
    logic [15:0] got;
    exp_q.push_back(exp);
    bus_read(a, use_w, got);
    check_eq(tag, got, exp_q.pop_front());
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_chk("rst_ctrl", B + 16'h00, 0, 16'h0000);
    read_chk("rst_status", B + 16'h07, 0, 16'h0000);
    read_chk("rst_cnt0", B + 16'h10, 0, 16'h0000);
    check_eq("rst_irq", {15'b0, irq}, 16'h0000);

    // read beside write returns the old value
    @(negedge clk);
    mm_we = 1'b1; mm_re = 1'b1; addr = B; wdata = 16'h0001;
    #1;
    check_eq("rw_same_cycle", rdata, 16'h0000);
    @(negedge clk);
    mm_we = 1'b0; mm_re = 1'b0;
    read_chk("ctrl_written", B + 16'h00, 0, 16'h0001);

    // test 1: mask selects channels 0 and 2
    bus_write(B + 16'h01, 16'h0005);
    read_chk("mask", B + 16'h01, 0, 16'h0005);
    inc = 4'b1111;
    repeat (10) @(negedge clk);
    inc = 4'b0000;
    read_chk("cnt0_10", B + 16'h10, 0, 16'd10);
    read_chk("cnt1_0", B + 16'h11, 0, 16'd0);
    read_chk("cnt2_10", B + 16'h12, 0, 16'd10);
    read_chk("cnt3_0", B + 16'h13, 0, 16'd0);

    // test 2: drive channel 0 from 10 to FFFE, then 3 more
    inc = 4'b0001;
    repeat (65524) @(negedge clk);
    inc = 4'b0000;
    read_chk("cnt0_fffe_sat", B + 16'h10, 0, 16'hFFFE);
    read_chk("cnt0_fffe_wrap", B + 16'h10, 1, 16'hFFFE);
    inc = 4'b0001;
    repeat (3) @(negedge clk);
    inc = 4'b0000;
    read_chk("cnt0_saturated", B + 16'h10, 0, 16'hFFFF);
    read_chk("cnt0_wrapped", B + 16'h10, 1, 16'h0001);

    // test 3: clear beats increment, snapshot takes pre-increment value
    @(negedge clk);
    mm_we = 1'b1; addr = B + 16'h02; wdata = 16'h0001; inc = 4'b0001;
    @(negedge clk);
    mm_we = 1'b0; inc = 4'b0000;
    read_chk("clr_vs_inc", B + 16'h10, 0, 16'h0000);
    read_chk("clr_keeps_cnt2", B + 16'h12, 0, 16'd10);
    read_chk("clr_reads_0", B + 16'h02, 0, 16'h0000);
    inc = 4'b0001;
    repeat (5) @(negedge clk);
    mm_we = 1'b1; addr = B + 16'h03; wdata = 16'h0001;
    @(negedge clk);
    mm_we = 1'b0; inc = 4'b0000;
    read_chk("snap0_pre_inc", B + 16'h20, 0, 16'd5);
    read_chk("live0_post_inc", B + 16'h10, 0, 16'd6);
    read_chk("snap2", B + 16'h22, 0, 16'd10);

    // test 4: prescaled timer, compare match, irq
    bus_write(B + 16'h05, 16'd3);
    bus_write(B + 16'h06, 16'd2);
    bus_write(B + 16'h04, 16'd0);
    bus_write(B + 16'h00, 16'h0006);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      read_chk($sformatf("timer_k%0d", k), B + 16'h04, 0,
               (k < 4) ? 16'd0 : (k < 8) ? 16'd1 : (k < 12) ? 16'd2 : 16'd0);
      if (k == 11) read_chk("status_pre_match", B + 16'h07, 0, 16'h0000);
      if (k == 12) begin
        read_chk("status_match", B + 16'h07, 0, 16'h0001);
        check_eq("irq_not_yet", {15'b0, irq}, 16'h0000);
      end
      if (k == 13) check_eq("irq_rise", {15'b0, irq}, 16'h0001);
    end
    bus_write(B + 16'h07, 16'h0001);
    read_chk("status_w1c", B + 16'h07, 0, 16'h0000);
    check_eq("irq_still_high", {15'b0, irq}, 16'h0001);
    @(negedge clk);
    check_eq("irq_fall", {15'b0, irq}, 16'h0000);
    bus_write(B + 16'h00, 16'h0004);

    // test 5: key edge capture
    @(negedge clk);
    #2 key = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    read_chk("key_edge", B + 16'h07, 0, 16'h0004);
    read_chk("keylvl", B + 16'h08, 0, 16'h0002);
    bus_write(B + 16'h07, 16'h0004);
    read_chk("key_w1c", B + 16'h07, 0, 16'h0000);
    repeat (5) @(negedge clk);
    read_chk("key_held_no_reset", B + 16'h07, 0, 16'h0000);
    key = 2'b00;
    repeat (4) @(negedge clk);
    key = 2'b10;
    @(negedge clk);
    bus_write(B + 16'h07, 16'h0004);
    read_chk("set_beats_clear", B + 16'h07, 0, 16'h0004);
    bus_write(B + 16'h07, 16'h0004);
    read_chk("key_clear_again", B + 16'h07, 0, 16'h0000);

    // test 6: unmapped reads, then reset mid-count
    read_chk("rd_clr_off", B + 16'h02, 0, 16'h0000);
    read_chk("rd_off_0f", B + 16'h0F, 0, 16'h0000);
    read_chk("rd_cnt_absent", B + 16'h14, 0, 16'h0000);
    read_chk("rd_below_base", B - 16'h0001, 0, 16'h0000);
    bus_write(B + 16'h00, 16'h0005);
    bus_write(B + 16'h01, 16'h000F);
    key = 2'b00;
    repeat (4) @(negedge clk);
    key = 2'b10;
    inc = 4'b1111;
    repeat (5) @(negedge clk);
    check_eq("irq_before_reset", {15'b0, irq}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_irq", {15'b0, irq}, 16'h0000);
    read_chk("reset_ctrl", B + 16'h00, 0, 16'h0000);
    read_chk("reset_mask", B + 16'h01, 0, 16'h0000);
    read_chk("reset_cnt0", B + 16'h10, 0, 16'h0000);
    read_chk("reset_snap0", B + 16'h20, 0, 16'h0000);
    read_chk("reset_status", B + 16'h07, 0, 16'h0000);
    read_chk("reset_keylvl", B + 16'h08, 0, 16'h0000);
    @(negedge clk);
    inc = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
